regfile_mp_sb: RTL and testbench

Parametrised multi-port integer register file with an integrated scoreboard, the next generation of the core's single-write, two-read register file.
- Provides NRD combinational read ports and NWR synchronous write ports, with deterministic write-collision priority.
- Keeps a per-register busy bit, set at instruction issue and cleared at writeback, so the decode stage can stall on RAW hazards.
- Sits between decode/issue and the writeback stage of the pipeline.

---
 rtl/regfile_pkg.sv | 16 +
 rtl/regfile_scoreboard.sv | 82 ++++++++
 rtl/regfile_mp_sb.sv | 93 +++++++++
 tb/tb_regfile_mp_sb.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults, address-width helper and data/address types for the register file.
package regfile_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;

    function automatic int addr_width(input int nreg);
        return (nreg > 1) ? $clog2(nreg) : 1;
    endfunction

    localparam int AW_DEF = addr_width(NREG_DEF);

    typedef logic [AW_DEF-1:0]   reg_addr_t;
    typedef logic [XLEN_DEF-1:0] reg_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits with issue/flush/writeback priority and an incrementally kept busy count.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int NWR  = 2,
    localparam int AW  = addr_width(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iss_en_i,
    input  logic [AW-1:0]     iss_addr_i,
    input  logic              flush_i,
    input  logic [NWR-1:0]    wr_en_i,
    input  logic [NWR*AW-1:0] wr_addr_i,
    output logic [NREG-1:0]   busy_o,
    output logic [AW:0]       cnt_o
);

    localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

    logic [NREG-1:1] busy_q, busy_d;
    logic [NREG-1:0] busy_full;
    logic [AW:0]     cnt_q, cnt_d;
    logic [AW:0]     n_clr;
    logic            iss_set;
    logic            clr_ok;

    assign busy_full = {busy_q, 1'b0};

    always_comb begin
        busy_d = busy_q;
        for (int r = 1; r < NREG; r++) begin
            if (flush_i) begin
                busy_d[r] = iss_en_i && (iss_addr_i == AW'(r));
            end else if (iss_en_i && (iss_addr_i == AW'(r))) begin
                busy_d[r] = 1'b1;
            end else begin
                for (int j = 0; j < NWR; j++) begin
                    if (wr_en_i[j] && (wr_addr_i[j*AW +: AW] == AW'(r)))
                        busy_d[r] = 1'b0;
                end
            end
        end
    end

    // Each write port retires at most one busy bit; only the highest port on a
    // shared address counts so duplicate writes are not double-subtracted.
    always_comb begin
        iss_set = iss_en_i && (iss_addr_i != '0) && !busy_full[iss_addr_i];
        n_clr   = '0;
        clr_ok  = 1'b0;
        for (int j = 0; j < NWR; j++) begin
            clr_ok = wr_en_i[j] && busy_full[wr_addr_i[j*AW +: AW]]
                     && !(iss_en_i && (iss_addr_i == wr_addr_i[j*AW +: AW]));
            for (int h = j + 1; h < NWR; h++) begin
                if (wr_en_i[h] && (wr_addr_i[h*AW +: AW] == wr_addr_i[j*AW +: AW]))
                    clr_ok = 1'b0;
            end
            if (clr_ok)
                n_clr = n_clr + CNT_ONE;
        end
        if (flush_i)
            cnt_d = (iss_en_i && (iss_addr_i != '0)) ? CNT_ONE : '0;
        else
            cnt_d = cnt_q + (iss_set ? CNT_ONE : '0) - n_clr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_o = busy_full;
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file (x0 hardwired zero) with RAW scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data and busy state to the read ports.
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int NRD  = 2,
    parameter int NWR  = 2,
    localparam int AW  = addr_width(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    input  logic                flush,
    output logic [AW:0]         busy_cnt
);

    logic [XLEN-1:0] regs_q [1:NREG-1];
    logic [XLEN-1:0] regs_d [1:NREG-1];
    logic [NREG-1:0] busy_vec;

    // Ascending port order makes the highest-index writer win on a collision.
    always_comb begin
        regs_d = regs_q;
        for (int r = 1; r < NREG; r++) begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && (wr_addr[j*AW +: AW] == AW'(r)))
                    regs_d[r] = wr_data[j*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 1; r < NREG; r++)
                regs_q[r] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    regfile_scoreboard #(
        .NREG (NREG),
        .NWR  (NWR)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .iss_en_i   (iss_en),
        .iss_addr_i (iss_addr),
        .flush_i    (flush),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .busy_o     (busy_vec),
        .cnt_o      (busy_cnt)
    );

    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
        logic [AW-1:0]   rd_addr_k;
        logic [XLEN-1:0] rd_data_k;
        logic            rd_busy_k;

        assign rd_addr_k = rd_addr[gi*AW +: AW];

        always_comb begin
            rd_data_k = '0;
            for (int r = 1; r < NREG; r++) begin
                if (rd_addr_k == AW'(r))
                    rd_data_k = regs_q[r];
            end
            rd_busy_k = busy_vec[rd_addr_k];
`ifdef REGFILE_BYPASS_EN
            for (int j = 0; j < NWR; j++) begin
                if (!rst && wr_en[j] && (rd_addr_k != '0) && (wr_addr[j*AW +: AW] == rd_addr_k)) begin
                    rd_data_k = wr_data[j*XLEN +: XLEN];
                    rd_busy_k = iss_en && (iss_addr == rd_addr_k);
                end
            end
`endif
        end

        assign rd_data[gi*XLEN +: XLEN] = rd_data_k;
        assign rd_busy[gi]              = rd_busy_k;
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb: directed vector table, hand-written corner sequences
// and randomized traffic against a reference model (read expectations follow REGFILE_BYPASS_EN).
module tb_regfile_mp_sb;
    import regfile_pkg::*;

    localparam int XLEN = XLEN_DEF;
    localparam int NREG = NREG_DEF;
    localparam int NRD  = 2;
    localparam int NWR  = 2;
    localparam int AW   = AW_DEF;

    logic                clk;
    logic                rst;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                iss_en;
    logic [AW-1:0]       iss_addr;
    logic                flush;
    logic [AW:0]         busy_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    regfile_mp_sb #(
        .XLEN (XLEN),
        .NREG (NREG),
        .NRD  (NRD),
        .NWR  (NWR)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .flush    (flush),
        .busy_cnt (busy_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [1:0] we;
        reg_addr_t  wa0, wa1;
        reg_data_t  wd0, wd1;
        logic       ie;
        reg_addr_t  ia;
        logic       fl;
        reg_addr_t  ra0, ra1;
        reg_data_t  ed0, ed1;
        logic [1:0] eb;
        logic [AW:0] ec;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    // Reference model state
    reg_data_t m_regs [NREG];
    logic      m_busy [NREG];

    reg_addr_t r_wa [NWR];
    reg_data_t r_wd [NWR];
    logic [NWR-1:0] r_we;
    logic      r_ie, r_fl;
    reg_addr_t r_ia;
    reg_addr_t r_ra [NRD];

    function automatic vec_t mk(input logic [31:0] we, wa0, wa1, wd0, wd1, ie, ia, fl,
                                input logic [31:0] ra0, ra1, ed0, ed1, eb, ec);
        vec_t v;
        v.we = we[1:0];  v.wa0 = wa0[AW-1:0]; v.wa1 = wa1[AW-1:0];
        v.wd0 = wd0;     v.wd1 = wd1;
        v.ie = ie[0];    v.ia = ia[AW-1:0];   v.fl = fl[0];
        v.ra0 = ra0[AW-1:0]; v.ra1 = ra1[AW-1:0];
        v.ed0 = ed0;     v.ed1 = ed1;
        v.eb = eb[1:0];  v.ec = ec[AW:0];
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic [1:0] we, input reg_addr_t wa0, input reg_addr_t wa1,
                         input reg_data_t wd0, input reg_data_t wd1, input logic ie,
                         input reg_addr_t ia, input logic fl, input reg_addr_t ra0,
                         input reg_addr_t ra1);
        wr_en    = we;
        wr_addr  = {wa1, wa0};
        wr_data  = {wd1, wd0};
        iss_en   = ie;
        iss_addr = ia;
        flush    = fl;
        rd_addr  = {ra1, ra0};
    endtask

    task automatic idle(input reg_addr_t ra0, input reg_addr_t ra1);
        drive(2'b00, '0, '0, '0, '0, 1'b0, '0, 1'b0, ra0, ra1);
    endtask

    function automatic reg_addr_t rand_addr();
        if ($urandom_range(0, 3) == 0) return reg_addr_t'($urandom_range(0, NREG - 1));
        return reg_addr_t'($urandom_range(0, 7));
    endfunction

    initial begin
        // we wa0 wa1 wd0 wd1 ie ia fl ra0 ra1 ed0 ed1 eb ec
        vecs[0]  = mk(1, 5, 0, 'hDEAD, 0,      0, 0, 0,  5, 0,  'hDEAD, 0,      0, 0);
        vecs[1]  = mk(3, 7, 7, 'h1111, 'h2222, 0, 0, 0,  7, 5,  'h2222, 'hDEAD, 0, 0);
        vecs[2]  = mk(1, 0, 0, 'hFFFF, 0,      0, 0, 0,  0, 7,  0,      'h2222, 0, 0);
        vecs[3]  = mk(0, 0, 0, 0, 0,           1, 3, 0,  3, 0,  0,      0,      1, 1);
        vecs[4]  = mk(0, 0, 0, 0, 0,           0, 0, 0,  3, 5,  0,      'hDEAD, 1, 1);
        vecs[5]  = mk(2, 0, 3, 0, 'h55,        0, 0, 0,  3, 5,  'h55,   'hDEAD, 0, 0);
        vecs[6]  = mk(0, 0, 0, 0, 0,           1, 4, 0,  4, 3,  0,      'h55,   1, 1);
        vecs[7]  = mk(1, 4, 0, 'h77, 0,        1, 4, 0,  4, 0,  'h77,   0,      1, 1);
        vecs[8]  = mk(0, 0, 0, 0, 0,           1, 0, 0,  0, 4,  0,      'h77,   2, 1);
        vecs[9]  = mk(1, 4, 0, 'h88, 0,        0, 0, 0,  4, 0,  'h88,   0,      0, 0);
        vecs[10] = mk(0, 0, 0, 0, 0,           1, 1, 0,  1, 2,  0,      0,      1, 1);
        vecs[11] = mk(0, 0, 0, 0, 0,           1, 2, 0,  1, 2,  0,      0,      3, 2);
        vecs[12] = mk(0, 0, 0, 0, 0,           1, 9, 0,  9, 1,  0,      0,      3, 3);
        vecs[13] = mk(0, 0, 0, 0, 0,           1, 10, 1, 10, 9, 0,      0,      1, 1);
        vecs[14] = mk(0, 0, 0, 0, 0,           0, 0, 1,  10, 1, 0,      0,      0, 0);
        vecs[15] = mk(3, 12, 13, 'hAAAA, 'hBBBB, 0, 0, 0, 12, 13, 'hAAAA, 'hBBBB, 0, 0);
        vecs[16] = mk(3, 2, 12, 'hC0DE, 1,     1, 2, 0,  2, 12, 'hC0DE, 1,      1, 1);
        vecs[17] = mk(3, 2, 2, 3, 4,           0, 0, 0,  2, 0,  4,      0,      0, 0);

        rst = 1'b1;
        idle(5, 0);
        #1;
        check("reset_cnt", busy_cnt, 0);
        check("reset_busy", rd_busy, 0);
        check("reset_data", rd_data, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Directed table: one edge per row, then read back with idle controls
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].we, vecs[i].wa0, vecs[i].wa1, vecs[i].wd0, vecs[i].wd1,
                  vecs[i].ie, vecs[i].ia, vecs[i].fl, vecs[i].ra0, vecs[i].ra1);
            @(posedge clk);
            #1;
            idle(vecs[i].ra0, vecs[i].ra1);
            #1;
            check($sformatf("v%0d_data0", i), rd_data[XLEN-1:0], vecs[i].ed0);
            check($sformatf("v%0d_data1", i), rd_data[2*XLEN-1:XLEN], vecs[i].ed1);
            check($sformatf("v%0d_busy0", i), rd_busy[0], vecs[i].eb[0]);
            check($sformatf("v%0d_busy1", i), rd_busy[1], vecs[i].eb[1]);
            check($sformatf("v%0d_cnt", i), busy_cnt, vecs[i].ec);
        end

        // Same-cycle read of a register being written back
        drive(2'b01, 6, 0, 'h1234, 0, 1'b1, 6, 1'b0, 6, 6);
        @(posedge clk);
        #1;
        drive(2'b01, 6, 0, 'hABCD, 0, 1'b0, 0, 1'b0, 6, 0);
        #1;
`ifdef REGFILE_BYPASS_EN
        check("byp_same_data", rd_data[XLEN-1:0], 'hABCD);
        check("byp_same_busy", rd_busy[0], 1'b0);
`else
        check("byp_same_data", rd_data[XLEN-1:0], 'h1234);
        check("byp_same_busy", rd_busy[0], 1'b1);
`endif
        check("byp_same_cnt", busy_cnt, 1);
        @(posedge clk);
        #1;
        idle(6, 0);
        #1;
        check("byp_next_data", rd_data[XLEN-1:0], 'hABCD);
        check("byp_next_busy", rd_busy[0], 1'b0);
        check("byp_next_cnt", busy_cnt, 0);

        // Asynchronous reset mid-run with live state
        drive(2'b00, 0, 0, 0, 0, 1'b1, 8, 1'b0, 8, 5);
        @(posedge clk);
        #1;
        idle(8, 5);
        #1;
        check("pre_rst_busy", rd_busy[0], 1'b1);
        check("pre_rst_data", rd_data[2*XLEN-1:XLEN], 'hDEAD);
        rst = 1'b1;
        #1;
        check("rst_cnt_now", busy_cnt, 0);
        check("rst_busy_now", rd_busy, 0);
        check("rst_data_now", rd_data, 0);
        for (int a = 0; a < NREG; a++) begin
            idle(reg_addr_t'(a), reg_addr_t'(NREG - 1 - a));
            #1;
            check($sformatf("rst_x%0d", a), rd_data, 0);
            check($sformatf("rst_busy_x%0d", a), rd_busy, 0);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            m_regs[r] = '0;
            m_busy[r] = 1'b0;
        end

        // Randomized traffic against the reference model
        @(posedge clk);
        #1;
        for (int c = 0; c < 400; c++) begin
            int pop;
            r_we = NWR'($urandom_range(0, 3));
            for (int j = 0; j < NWR; j++) begin
                r_wa[j] = rand_addr();
                r_wd[j] = $urandom;
            end
            r_ie = ($urandom_range(0, 2) == 0);
            r_ia = rand_addr();
            r_fl = ($urandom_range(0, 15) == 0);
            for (int k = 0; k < NRD; k++) r_ra[k] = rand_addr();
            drive(r_we, r_wa[0], r_wa[1], r_wd[0], r_wd[1], r_ie, r_ia, r_fl, r_ra[0], r_ra[1]);
            #1;
            for (int k = 0; k < NRD; k++) begin
                reg_data_t ed;
                logic      eb;
                ed = m_regs[r_ra[k]];
                eb = m_busy[r_ra[k]];
`ifdef REGFILE_BYPASS_EN
                for (int j = 0; j < NWR; j++) begin
                    if (r_we[j] && r_wa[j] == r_ra[k] && r_ra[k] != 0) begin
                        ed = r_wd[j];
                        eb = r_ie && (r_ia == r_ra[k]);
                    end
                end
`endif
                check($sformatf("rnd%0d_data%0d", c, k), rd_data[k*XLEN +: XLEN], ed);
                check($sformatf("rnd%0d_busy%0d", c, k), rd_busy[k], eb);
            end
            pop = 0;
            for (int r = 0; r < NREG; r++) pop += int'(m_busy[r]);
            check($sformatf("rnd%0d_cnt", c), busy_cnt, pop);
            @(posedge clk);
            for (int j = 0; j < NWR; j++) begin
                if (r_we[j] && r_wa[j] != 0) m_regs[r_wa[j]] = r_wd[j];
                if (r_we[j]) m_busy[r_wa[j]] = 1'b0;
            end
            if (r_fl)
                for (int r = 0; r < NREG; r++) m_busy[r] = 1'b0;
            if (r_ie && r_ia != 0) m_busy[r_ia] = 1'b1;
            m_busy[0] = 1'b0;
            #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
